// File: rtl/fft_input_loader.sv
// Serial-to-parallel frame loader for the full-parallel FFT, ping-pong banked, optional bit-reversed slots.
// Latency: last sample accepted at edge t -> dout_valid visible in cycle t+1.
// Backpressure: din_busy only when the write bank is still FULL; dout_busy holds the presented frame stable.
module fft_input_loader #(
    parameter int WIDTH  = 16,
    parameter int NPOINT = 3,
    parameter int BITREV = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          din_valid,
    output logic                          din_busy,
    input  logic                          din_first,
    input  logic [WIDTH-1:0]              din_real,
    input  logic [WIDTH-1:0]              din_imag,
    output logic                          dout_valid,
    input  logic                          dout_busy,
    output logic [WIDTH*(2**NPOINT)-1:0]  dout_real,
    output logic [WIDTH*(2**NPOINT)-1:0]  dout_imag,
    output logic                          frame_err
);

    localparam int N = 2 ** NPOINT;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL
    } bank_st_t;

    bank_st_t          bank_st     [2];
    bank_st_t          bank_st_nxt [2];
    logic              wr_bank, wr_bank_nxt;
    logic              rd_bank, rd_bank_nxt;
    logic [NPOINT-1:0] wr_cnt, wr_cnt_nxt;
    logic              frame_err_nxt;

    logic              din_tran;
    logic              dout_tran;
    logic              restart;
    logic              last;
    logic [NPOINT-1:0] eff_cnt;
    logic [NPOINT-1:0] wr_slot;

    logic [WIDTH-1:0]  mem_re [2][N];
    logic [WIDTH-1:0]  mem_im [2][N];

    function automatic logic [NPOINT-1:0] bitrev(input logic [NPOINT-1:0] v);
        logic [NPOINT-1:0] r;
        for (int i = 0; i < NPOINT; i++) begin
            r[i] = v[NPOINT-1-i];
        end
        return r;
    endfunction

    // Handshake outputs depend on registered bank state only.
    assign din_busy   = (bank_st[wr_bank] == BANK_FULL);
    assign dout_valid = (bank_st[rd_bank] == BANK_FULL);
    assign din_tran   = din_valid && !din_busy;
    assign dout_tran  = dout_valid && !dout_busy;

    // An early din_first drops the partial frame and restarts the count at this sample.
    assign restart = din_tran && din_first && (wr_cnt != '0);
    assign eff_cnt = restart ? '0 : wr_cnt;
    assign last    = &eff_cnt;
    assign wr_slot = (BITREV != 0) ? bitrev(eff_cnt) : eff_cnt;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            bank_st[0] <= BANK_EMPTY;
            bank_st[1] <= BANK_EMPTY;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_cnt     <= '0;
            frame_err  <= 1'b0;
        end else begin
            bank_st[0] <= bank_st_nxt[0];
            bank_st[1] <= bank_st_nxt[1];
            wr_bank    <= wr_bank_nxt;
            rd_bank    <= rd_bank_nxt;
            wr_cnt     <= wr_cnt_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    always_comb begin
        bank_st_nxt[0] = bank_st[0];
        bank_st_nxt[1] = bank_st[1];
        wr_bank_nxt    = wr_bank;
        rd_bank_nxt    = rd_bank;
        wr_cnt_nxt     = wr_cnt;
        frame_err_nxt  = frame_err;

        // A write and a read can never target the same bank in one cycle.
        if (dout_tran) begin
            bank_st_nxt[rd_bank] = BANK_EMPTY;
            rd_bank_nxt          = !rd_bank;
        end

        if (din_tran) begin
            if (last) begin
                bank_st_nxt[wr_bank] = BANK_FULL;
                wr_bank_nxt          = !wr_bank;
                wr_cnt_nxt           = '0;
            end else begin
                bank_st_nxt[wr_bank] = BANK_FILLING;
                wr_cnt_nxt           = eff_cnt + 1'b1;
            end
            if (restart) begin
                frame_err_nxt = 1'b1;
            end
        end
    end

    // Sample storage carries no reset.
    always_ff @(posedge clk) begin
        if (din_tran && !rst_n) begin
            mem_re[wr_bank][wr_slot] <= din_real;
            mem_im[wr_bank][wr_slot] <= din_imag;
        end
    end

    always_comb begin
        dout_real = '0;
        dout_imag = '0;
        for (int k = 0; k < N; k++) begin
            dout_real[k*WIDTH +: WIDTH] = mem_re[rd_bank][k];
            dout_imag[k*WIDTH +: WIDTH] = mem_im[rd_bank][k];
        end
    end

endmodule

// File: tb/tb_fft_input_loader.sv
// Scoreboard bench for fft_input_loader: bit-reversed and linear instances share one stimulus stream.
module tb_fft_input_loader;

    localparam int W  = 16;
    localparam int NP = 3;
    localparam int N  = 8;
    localparam int FW = W * N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          din_valid;
    logic          din_first;
    logic [W-1:0]  din_real;
    logic [W-1:0]  din_imag;
    logic          dout_busy = 1'b0;

    logic          din_busy_br, dout_valid_br, frame_err_br;
    logic          din_busy_ln, dout_valid_ln, frame_err_ln;
    logic [FW-1:0] dout_real_br, dout_imag_br, dout_real_ln, dout_imag_ln;

    int n_chk  = 0;
    int n_fail = 0;
    int busy_seen = 0;
    int busy_mode = 0;

    logic [FW-1:0] q_re_br[$], q_im_br[$], q_re_ln[$], q_im_ln[$];
    logic [FW-1:0] m_re_br, m_im_br, m_re_ln, m_im_ln;
    int m_cnt = 0;

    always #5 clk = ~clk;

    fft_input_loader #(.WIDTH(W), .NPOINT(NP), .BITREV(1)) u_br (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_busy(din_busy_br),
        .din_first(din_first), .din_real(din_real), .din_imag(din_imag),
        .dout_valid(dout_valid_br), .dout_busy(dout_busy),
        .dout_real(dout_real_br), .dout_imag(dout_imag_br), .frame_err(frame_err_br)
    );

    fft_input_loader #(.WIDTH(W), .NPOINT(NP), .BITREV(0)) u_ln (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_busy(din_busy_ln),
        .din_first(din_first), .din_real(din_real), .din_imag(din_imag),
        .dout_valid(dout_valid_ln), .dout_busy(dout_busy),
        .dout_real(dout_real_ln), .dout_imag(dout_imag_ln), .frame_err(frame_err_ln)
    );

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int brev(input int n);
        int r = 0;
        for (int b = 0; b < NP; b++) begin
            r = r | (((n >> b) & 1) << (NP - 1 - b));
        end
        return r;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        q_re_br.delete(); q_im_br.delete();
        q_re_ln.delete(); q_im_ln.delete();
    endtask

    task automatic model_push(input int re, input int im, input logic first);
        if (first && m_cnt != 0) m_cnt = 0;
        m_re_ln[m_cnt*W +: W]       = W'(re);
        m_im_ln[m_cnt*W +: W]       = W'(im);
        m_re_br[brev(m_cnt)*W +: W] = W'(re);
        m_im_br[brev(m_cnt)*W +: W] = W'(im);
        m_cnt++;
        if (m_cnt == N) begin
            q_re_br.push_back(m_re_br); q_im_br.push_back(m_im_br);
            q_re_ln.push_back(m_re_ln); q_im_ln.push_back(m_im_ln);
            m_cnt = 0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input int re, input int im, input logic first);
        int guard = 0;
        din_valid = 1'b1;
        din_first = first;
        din_real  = W'(re);
        din_imag  = W'(im);
        while ((din_busy_br || din_busy_ln) && guard < 200) begin
            busy_seen++;
            guard++;
            tick();
        end
        if (guard >= 200) chk("send_timeout", FW'(guard), FW'(0));
        tick();
        model_push(re, im, first);
    endtask

    // dout_busy driver: 0 = ready, 1 = held busy, 2 = random with at most 4 busy cycles in a row.
    initial begin
        int hold = 0;
        forever begin
            @(posedge clk);
            #2;
            case (busy_mode)
                0: dout_busy = 1'b0;
                1: dout_busy = 1'b1;
                default: dout_busy = (hold >= 4) ? 1'b0 : 1'($urandom_range(0, 1));
            endcase
            hold = dout_busy ? hold + 1 : 0;
        end
    end

    // Monitor: every frame transfer is popped and compared against the scoreboard.
    initial begin
        logic [FW-1:0] e_re, e_im;
        forever begin
            @(negedge clk);
            if (!rst_n && dout_valid_br && !dout_busy) begin
                if (q_re_br.size() == 0) chk("br_unexpected_frame", FW'(q_re_br.size()), FW'(1));
                else begin
                    e_re = q_re_br.pop_front(); e_im = q_im_br.pop_front();
                    chk("br_frame_real", dout_real_br, e_re);
                    chk("br_frame_imag", dout_imag_br, e_im);
                end
            end
            if (!rst_n && dout_valid_ln && !dout_busy) begin
                if (q_re_ln.size() == 0) chk("ln_unexpected_frame", FW'(q_re_ln.size()), FW'(1));
                else begin
                    e_re = q_re_ln.pop_front(); e_im = q_im_ln.pop_front();
                    chk("ln_frame_real", dout_real_ln, e_re);
                    chk("ln_frame_imag", dout_imag_ln, e_im);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; din_valid = 1'b0; din_first = 1'b0; din_real = '0; din_imag = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_dout_valid_br", FW'(dout_valid_br), FW'(0));
        chk("reset_dout_valid_ln", FW'(dout_valid_ln), FW'(0));
        chk("reset_din_busy",      FW'(din_busy_br),   FW'(0));
        chk("reset_frame_err",     FW'(frame_err_br),  FW'(0));
        tick();

        // Eight back-to-back samples, real=n imag=-n.
        for (int n = 0; n < 8; n++) send(n, -n, n == 0);
        din_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid_br",      FW'(dout_valid_br), FW'(1));
        chk("t1_valid_ln",      FW'(dout_valid_ln), FW'(1));
        chk("t1_br_slot4_re",   FW'(dout_real_br[4*W +: W]), FW'(16'd1));
        chk("t1_br_slot4_im",   FW'(dout_imag_br[4*W +: W]), FW'(16'hFFFF));
        chk("t1_br_slot3_re",   FW'(dout_real_br[3*W +: W]), FW'(16'd6));
        chk("t1_br_slot7_re",   FW'(dout_real_br[7*W +: W]), FW'(16'd7));
        chk("t1_ln_slot3_re",   FW'(dout_real_ln[3*W +: W]), FW'(16'd3));
        chk("t1_ln_slot4_im",   FW'(dout_imag_ln[4*W +: W]), FW'(16'hFFFC));
        @(negedge clk);
        chk("t1_valid_drop_br", FW'(dout_valid_br), FW'(0));
        chk("t1_valid_drop_ln", FW'(dout_valid_ln), FW'(0));
        tick();

        // Downstream held busy across two frames.
        busy_mode = 1;
        busy_seen = 0;
        for (int n = 0; n < 16; n++) send(n, -n, 1'b0);
        din_valid = 1'b0;
        chk("t3_no_stall_16", FW'(busy_seen), FW'(0));
        @(negedge clk);
        chk("t3_din_busy_full", FW'(din_busy_br),  FW'(1));
        chk("t3_valid_held",    FW'(dout_valid_ln), FW'(1));
        chk("t3_frame0_slot7",  FW'(dout_real_ln[7*W +: W]), FW'(16'd7));
        tick();
        busy_mode = 0;
        tick();
        busy_mode = 1;
        @(negedge clk);
        chk("t3_din_busy_freed", FW'(din_busy_br),   FW'(0));
        chk("t3_valid_second",   FW'(dout_valid_br), FW'(1));
        chk("t3_frame1_slot0",   FW'(dout_real_ln[0*W +: W]), FW'(16'd8));
        tick();
        busy_mode = 0;
        repeat (3) tick();

        // Early din_first drops the partial frame.
        for (int n = 0; n < 5; n++) send(n, -n, n == 0);
        send(100, -100, 1'b1);
        for (int n = 1; n < 8; n++) send(100 + n, -(100 + n), 1'b0);
        din_valid = 1'b0;
        @(negedge clk);
        chk("t4_frame_err_br", FW'(frame_err_br), FW'(1));
        chk("t4_frame_err_ln", FW'(frame_err_ln), FW'(1));
        chk("t4_valid",        FW'(dout_valid_ln), FW'(1));
        chk("t4_ln_slot0",     FW'(dout_real_ln[0*W +: W]), FW'(16'd100));
        chk("t4_br_slot0",     FW'(dout_real_br[0*W +: W]), FW'(16'd100));
        chk("t4_ln_slot1",     FW'(dout_real_ln[1*W +: W]), FW'(16'd101));
        tick();
        repeat (3) tick();

        // Five frames at full rate with random short downstream stalls.
        busy_mode = 2;
        busy_seen = 0;
        for (int f = 0; f < 5; f++)
            for (int s = 0; s < 8; s++) send(1000 + f*8 + s, 16'h5A00 ^ (f*8 + s), s == 0);
        din_valid = 1'b0;
        chk("t5_no_stall", FW'(busy_seen), FW'(0));
        repeat (8) tick();
        busy_mode = 0;
        repeat (3) tick();
        chk("t5_drained_br", FW'(q_re_br.size()), FW'(0));
        chk("t5_drained_ln", FW'(q_re_ln.size()), FW'(0));
        chk("t5_frame_err_sticky", FW'(frame_err_br), FW'(1));

        // Reset mid-frame.
        for (int n = 0; n < 6; n++) send(300 + n, -(300 + n), n == 0);
        din_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_valid_br",     FW'(dout_valid_br), FW'(0));
        chk("t6_valid_ln",     FW'(dout_valid_ln), FW'(0));
        chk("t6_din_busy",     FW'(din_busy_br),   FW'(0));
        chk("t6_frame_err_clr", FW'(frame_err_br), FW'(0));
        tick();
        for (int n = 0; n < 8; n++) send(400 + n, -(400 + n), 1'b0);
        din_valid = 1'b0;
        @(negedge clk);
        chk("t6_valid_after", FW'(dout_valid_ln), FW'(1));
        chk("t6_ln_slot0",    FW'(dout_real_ln[0*W +: W]), FW'(16'd400));
        chk("t6_br_slot4",    FW'(dout_real_br[4*W +: W]), FW'(16'd401));
        tick();
        repeat (3) tick();

        chk("final_drained_br", FW'(q_re_br.size()), FW'(0));
        chk("final_drained_ln", FW'(q_re_ln.size()), FW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_input_loader.md
Name: fft_input_loader

Overview:
- Upstream stage of the full-parallel FFT; sits directly in front of the first butterfly stage.
- Accepts complex samples serially, one per transfer, and assembles 2**NPOINT of them into a frame.
- Optionally stores samples in bit-reversed order.
- Presents each complete frame as a flat parallel vector on a valid/busy handshake.
- Ping-pong (two-bank) buffering: bank A can be filled while bank B waits on downstream.

Parameters:
- WIDTH, 16, bits per real/imag component (two's complement).
- NPOINT, 3, log2 of frame size; N = 2**NPOINT samples per frame.
- BITREV, 1, 1: sample n stored in slot bitrev_NPOINT(n); 0: stored in slot n.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-high (1 = reset), despite the suffix.
- din_valid  in  1  serial sample valid.
- din_busy  out  1  loader cannot accept; transfer when din_valid && !din_busy.
- din_first  in  1  qualifies the current sample as sample 0 of a frame (sampled only on transfer).
- din_real  in  WIDTH  sample real part.
- din_imag  in  WIDTH  sample imag part.
- dout_valid  out  1  a complete frame is presented.
- dout_busy  in  1  downstream busy; frame transfer when dout_valid && !dout_busy.
- dout_real  out  WIDTH*N  frame real parts; slot k at [k*WIDTH +: WIDTH].
- dout_imag  out  WIDTH*N  frame imag parts; same packing.
- frame_err  out  1  sticky: a frame was restarted early by din_first.

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - Both banks EMPTY; wr_bank=0, rd_bank=0, wr_cnt=0.
  - din_busy=0, dout_valid=0, frame_err=0.
  - Bank storage is not cleared; dout_real/dout_imag are don't-care while dout_valid=0.
  - Reset mid-frame or mid-handshake discards everything, with no partial output.
- Per-bank state: EMPTY -> FILLING (first accepted sample) -> FULL (N-th sample accepted) -> EMPTY (frame transfer out of that bank).
- Input transfer (din_tran):
  - Write {din_real, din_imag} to slot (BITREV ? bitrev(wr_cnt) : wr_cnt) of wr_bank; wr_cnt++.
  - When wr_cnt == N-1 on the transfer: wr_cnt wraps to 0, wr_bank becomes FULL, and wr_bank toggles.
- Frame alignment with din_first:
  - din_first=1 on a transfer with wr_cnt != 0: the partial frame is dropped, the sample is written as sample 0 (wr_cnt becomes 1), and frame_err is set.
  - din_first=1 with wr_cnt==0: normal.
  - din_first is never required; a free-running count is legal.
- din_busy = (state of wr_bank == FULL). Combinational from registers only; no combinational path from din_valid or dout_busy.
- dout_valid = (state of rd_bank == FULL).
- dout_real/dout_imag are a mux of rd_bank storage and are stable while dout_valid=1 && dout_busy=1.
- On a frame transfer (dout_tran): rd_bank becomes EMPTY and rd_bank toggles.
- Latency: last sample of a frame accepted at edge t gives dout_valid=1 after edge t, i.e. visible in cycle t+1.
- Simultaneous events:
  - dout_tran freeing bank X in the same cycle the last sample completes bank Y: both take effect, and dout_valid stays 1 for bank Y in the next cycle.
  - Both banks FULL gives din_busy=1. The cycle after dout_tran frees a bank, din_busy=0.
  - Throughput: sustains one sample per cycle indefinitely if downstream accepts within N cycles of dout_valid.
- frame_err clears only on reset.
- No arithmetic on data; bit-exact pass-through.

Test Plan:
- Reset, then 8 back-to-back samples real=n, imag=-n (n=0..7), BITREV=1, dout_busy=0 -> dout_valid is high one cycle after sample 7. Slot 4 holds real=1, imag=-1; slot 3 holds real=6; slot 7 holds real=7. dout_valid is low again the following cycle.
- Same stimulus with BITREV=0 -> slot k holds real=k for all k.
- dout_busy held 1; stream 16 samples -> din_busy=0 through sample 15 and =1 from the cycle after sample 15. Release dout_busy for one cycle -> first frame (values 0..7) transfers, din_busy=0 next cycle, and the second frame (8..15) is presented with dout_valid still 1.
- Samples 0..4, then din_first=1 with value 100, then 7 more samples -> frame_err=1 and remains 1. The output frame's sample 0 is 100, with no frame emitted containing samples 0..4.
- Continuous 1-sample/cycle stream of 5 frames with dout_busy random at 50% but never holding more than 4 cycles -> din_busy never asserts, and all 5 frames are delivered in order and bit-exact.
- Assert rst_n for one cycle after sample 5 of a frame -> dout_valid=0 and din_busy=0. The next 8 samples form a complete frame that starts at sample 0.
